uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: OVERSAMPLE, default 8, CLK cycles per serial bit; legal values 8, 16, 32.
REQ-002 SHALL have port: CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: RST  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port: RX_IN  input  1  serial line; idle high; asynchronous to CLK.
REQ-005 SHALL have port: PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-006 SHALL have port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 SHALL have port: P_DATA  output  8  last correctly received byte.
REQ-008 SHALL have port: Data_Valid  output  1  one-cycle pulse; P_DATA holds a new byte.
REQ-009 SHALL have port: par_err  output  1  one-cycle pulse; parity mismatch.
REQ-010 SHALL have port: stop_err  output  1  one-cycle pulse; stop bit sampled 0.
REQ-011 SHALL have port: busy  output  1  high while a frame is being received.

Function
REQ-012 SHALL pass RX_IN through a 2-flop synchronizer (both flops reset to 1); rx_s, its output, is the only RX_IN-derived signal used; all timing below refers to rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, using an oversample counter 0..OVERSAMPLE-1 and a bit counter 0..7.
REQ-014 In IDLE, rx_s = 0 SHALL move to START; that cycle is frame cycle 0 (oversample count 0), and PAR_EN/PAR_TYP SHALL be latched then and held for the frame.
REQ-015 Each bit SHALL occupy OVERSAMPLE cycles; bit value = majority of rx_s at oversample counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-016 START: a majority value of 1 (glitch) SHALL return to IDLE at the end of that bit, with no output pulses.
REQ-017 DATA: 8 bits, LSB first, shifted into an internal register; then PARITY if the latched PAR_EN = 1, else STOP.
REQ-018 PARITY: error if the received parity bit differs from XOR(data) for even, or from ~XOR(data) for odd.
REQ-019 STOP: error if the stop bit majority is 0.
REQ-020 The frame SHALL end on the last oversample cycle of STOP; the FSM SHALL be in IDLE on the next cycle (frame cycle 10*OVERSAMPLE without parity, 11*OVERSAMPLE with parity); a start bit is detectable in that same cycle, so back-to-back frames are received.
REQ-021 In the cycle after frame end, SHALL pulse exactly one outcome:
- no errors: Data_Valid = 1 and P_DATA updated.
- otherwise: par_err and/or stop_err = 1, Data_Valid = 0, P_DATA unchanged.
REQ-022 P_DATA SHALL change only with a Data_Valid pulse and hold otherwise.
REQ-023 busy SHALL be 1 from the cycle after start detection through the frame-end cycle, and 0 otherwise.
REQ-024 Changes on PAR_EN/PAR_TYP mid-frame SHALL have no effect until the next start detection.

Reset
REQ-025 On RST = 0 at a rising edge: FSM = IDLE; counters = 0; P_DATA = 8'h00; Data_Valid = par_err = stop_err = busy = 0; synchronizer flops = 1.
REQ-026 Reset mid-frame SHALL discard the partial frame with no output pulse; after release, reception SHALL resume only on a new 1->0 line transition seen in IDLE.

Verification (OVERSAMPLE = 8; cycles counted from the start-detect cycle)
REQ-027 PAR_EN = 0, send 0xA5 -> Data_Valid pulse at cycle 80, P_DATA = 0xA5, busy low at cycle 80.
REQ-028 PAR_EN = 1, PAR_TYP = 0, send 0x3C with parity bit 0 -> Data_Valid at cycle 88, P_DATA = 0x3C; same frame with parity bit 1 -> par_err pulse at cycle 88, no Data_Valid, P_DATA still 0x3C.
REQ-029 RX_IN low for 2 cycles, then high -> no pulses, busy low after cycle 8; a following valid 0x55 frame is received correctly.
REQ-030 Stop bit driven 0 with data 0xF0 -> stop_err pulse at cycle 80, Data_Valid = 0, P_DATA unchanged.
REQ-031 Two frames, 0x12 then 0x34, with zero idle bits between them -> Data_Valid at cycles 80 and 160, with P_DATA = 0x12 and then 0x34.
REQ-032 RST asserted at cycle 40 of a frame, released at cycle 45, with the line then idle -> all outputs 0 and no pulse; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional even/odd parity and majority-vote bit sampling
module uart_rx #(
    parameter int OVERSAMPLE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       Data_Valid,
    output logic       par_err,
    output logic       stop_err,
    output logic       busy
);
    localparam int W = $clog2(OVERSAMPLE);
    localparam logic [W-1:0] S0   = W'(OVERSAMPLE / 2 - 1);
    localparam logic [W-1:0] S1   = W'(OVERSAMPLE / 2);
    localparam logic [W-1:0] S2   = W'(OVERSAMPLE / 2 + 1);
    localparam logic [W-1:0] LAST = W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t       state, state_nxt;
    logic         rx_m, rx_s;
    logic [W-1:0] os_cnt;
    logic [2:0]   bit_cnt;
    logic [1:0]   samp;
    logic         bit_val, par_en_l, par_typ_l, par_bad;
    logic [7:0]   shreg;
    logic         bit_end, start_det, maj;

    assign bit_end   = os_cnt == LAST;
    assign start_det = state == IDLE && !rx_s;
    assign maj       = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
    assign busy      = state != IDLE;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = rx_s ? IDLE : START;
            START:   if (bit_end) state_nxt = bit_val ? IDLE : DATA;
            DATA:    if (bit_end && bit_cnt == 3'd7) state_nxt = par_en_l ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            {rx_s, rx_m} <= 2'b11;
            os_cnt       <= '0;
            bit_cnt      <= '0;
            samp         <= '0;
            bit_val      <= 1'b0;
            par_en_l     <= 1'b0;
            par_typ_l    <= 1'b0;
            par_bad      <= 1'b0;
            shreg        <= '0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
        end else begin
            {rx_s, rx_m} <= {rx_m, RX_IN};
            Data_Valid   <= 1'b0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
            // start-detect cycle is oversample count 0, so the next cycle is count 1
            if (start_det) begin
                os_cnt    <= W'(1);
                bit_cnt   <= '0;
                par_en_l  <= PAR_EN;
                par_typ_l <= PAR_TYP;
                par_bad   <= 1'b0;
            end else if (state != IDLE) begin
                os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
            end
            if (os_cnt == S0) samp[1] <= rx_s;
            if (os_cnt == S1) samp[0] <= rx_s;
            if (os_cnt == S2) bit_val <= maj;
            if (bit_end && state == DATA) begin
                shreg   <= {bit_val, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (bit_end && state == PARITY) par_bad <= bit_val != (^shreg ^ par_typ_l);
            if (bit_end && state == STOP) begin
                Data_Valid <= bit_val & ~par_bad;
                par_err    <= par_bad;
                stop_err   <= ~bit_val;
                if (bit_val & ~par_bad) P_DATA <= shreg;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus checked against a frame-level reference model
module tb_uart_rx;
    localparam int OS = 8;

    logic       CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid, par_err, stop_err, busy;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int         exp_cyc[$], act_cyc[$];
    logic [2:0] exp_kind[$], act_kind[$];
    logic [7:0] exp_data[$], act_data[$];
    int         bchk_cyc[$];
    logic       bchk_val[$];
    logic       busy_log[int];
    logic [7:0] model_pdata = 8'h00;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .Data_Valid(Data_Valid), .par_err(par_err),
        .stop_err(stop_err), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        busy_log[cyc] = busy;
        if (Data_Valid || par_err || stop_err) begin
            act_cyc.push_back(cyc);
            act_kind.push_back({Data_Valid, par_err, stop_err});
            act_data.push_back(P_DATA);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_busy(input int c, input logic v);
        bchk_cyc.push_back(c);
        bchk_val.push_back(v);
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (OS) @(negedge CLK);
    endtask

    // rx_s sees a line change two cycles later, so start detect is two cycles after driving
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pflip, input logic sv);
        int   c0, n;
        logic perr, serr;
        c0      = cyc + 2;
        n       = pe ? 11 : 10;
        PAR_EN  = pe;
        PAR_TYP = pt;
        drive_bit(1'b0);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit((^d) ^ pt ^ pflip);
        drive_bit(sv);
        perr = pe & pflip;
        serr = ~sv;
        if (!perr && !serr) model_pdata = d;
        exp_cyc.push_back(c0 + n * OS);
        exp_kind.push_back({~(perr | serr), perr, serr});
        exp_data.push_back(model_pdata);
        expect_busy(c0, 1'b0);
        expect_busy(c0 + 1, 1'b1);
        expect_busy(c0 + n * OS - 1, 1'b1);
        expect_busy(c0 + n * OS, 1'b0);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic verify(input string tag);
        idle(4);
        check({tag, " n_events"}, 32'(act_cyc.size()), 32'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < act_cyc.size(); i++) begin
            check({tag, " ev_cycle"}, 32'(act_cyc[i]), 32'(exp_cyc[i]));
            check({tag, " ev_kind"}, 32'(act_kind[i]), 32'(exp_kind[i]));
            check({tag, " ev_data"}, 32'(act_data[i]), 32'(exp_data[i]));
        end
        for (int i = 0; i < bchk_cyc.size(); i++)
            check({tag, " busy"}, 32'(busy_log[bchk_cyc[i]]), 32'(bchk_val[i]));
        check({tag, " p_data_hold"}, 32'(P_DATA), 32'(model_pdata));
        check({tag, " busy_end"}, 32'(busy), 32'(0));
        exp_cyc.delete(); exp_kind.delete(); exp_data.delete();
        act_cyc.delete(); act_kind.delete(); act_data.delete();
        bchk_cyc.delete(); bchk_val.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         c0;
        logic [9:0] fb;
        repeat (3) @(negedge CLK);
        check("rst p_data", 32'(P_DATA), 32'(0));
        check("rst outputs", 32'({Data_Valid, par_err, stop_err, busy}), 32'(0));
        RST = 1'b1;
        idle(4);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        verify("no_parity");

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        verify("even_parity");

        c0 = cyc + 2;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        idle(12);
        expect_busy(c0 + 7, 1'b1);
        expect_busy(c0 + 8, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        verify("glitch");

        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        verify("stop_err");

        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
        verify("back_to_back");

        c0 = cyc + 2;
        fb = {1'b1, 8'hC3, 1'b0};
        for (int t = 0; t < 41; t++) begin
            RX_IN = fb[t / OS];
            @(negedge CLK);
        end
        RST   = 1'b0;
        RX_IN = 1'b1;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        model_pdata = 8'h00;
        expect_busy(c0 + 39, 1'b1);
        expect_busy(c0 + 40, 1'b0);
        idle(20);
        check("mid_rst p_data", 32'(P_DATA), 32'(0));
        check("mid_rst busy", 32'(busy), 32'(0));
        send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1);
        verify("mid_reset");

        for (int f = 0; f < 40; f++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 20));
            if (f % 8 == 7) verify("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
